id_ex_latch: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core, placed between decode and execute.
- It presents the latched rs/rt/rd indices, operands and control to the EX stage and to the forwarding unit.
- It contains load-use hazard detection. On a hazard it stalls PC and IF/ID and injects a bubble into EX.
- It also handles flushes for taken branches and jumps, and debug step gating.

---
 rtl/id_ex_latch.sv | 186 ++++++++++++++++++
 tb/tb_id_ex_latch.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Holds the decoded instruction for the EX stage and the forwarding unit,
// detects load-use hazards against the instruction in ID, and turns flushes,
// hazards and debug-step freezes into the right register behaviour.
// An all-zero register set is the canonical bubble (NOP with rs=rt=rd=0).

module id_ex_latch #(
  parameter int NB_DATA   = 32,
  parameter int NB_REG    = 5,
  parameter int NB_ALU_OP = 4,
  parameter int NB_CNT    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_flush,
  input  logic [NB_REG-1:0]    i_rs,
  input  logic [NB_REG-1:0]    i_rt,
  input  logic [NB_REG-1:0]    i_rd,
  input  logic                 i_uses_rt,
  input  logic [NB_DATA-1:0]   i_data_a,
  input  logic [NB_DATA-1:0]   i_data_b,
  input  logic [NB_DATA-1:0]   i_imm,
  input  logic [NB_DATA-1:0]   i_pc,
  input  logic                 i_reg_wr_en,
  input  logic                 i_mem_rd_en,
  input  logic                 i_mem_wr_en,
  input  logic                 i_mem_to_reg,
  input  logic                 i_alu_src,
  input  logic                 i_reg_dst,
  input  logic [NB_ALU_OP-1:0] i_alu_op,
  output logic [NB_REG-1:0]    o_rs,
  output logic [NB_REG-1:0]    o_rt,
  output logic [NB_REG-1:0]    o_rd,
  output logic [NB_DATA-1:0]   o_data_a,
  output logic [NB_DATA-1:0]   o_data_b,
  output logic [NB_DATA-1:0]   o_imm,
  output logic [NB_DATA-1:0]   o_pc,
  output logic                 o_reg_wr_en,
  output logic                 o_mem_rd_en,
  output logic                 o_mem_wr_en,
  output logic                 o_mem_to_reg,
  output logic                 o_alu_src,
  output logic                 o_reg_dst,
  output logic [NB_ALU_OP-1:0] o_alu_op,
  output logic                 o_stall,
  output logic [NB_CNT-1:0]    o_stall_cnt
);

  logic [NB_REG-1:0]    rs_q, rs_d;
  logic [NB_REG-1:0]    rt_q, rt_d;
  logic [NB_REG-1:0]    rd_q, rd_d;
  logic [NB_DATA-1:0]   dataA_q, dataA_d;
  logic [NB_DATA-1:0]   dataB_q, dataB_d;
  logic [NB_DATA-1:0]   imm_q, imm_d;
  logic [NB_DATA-1:0]   pc_q, pc_d;
  logic                 regWrEn_q, regWrEn_d;
  logic                 memRdEn_q, memRdEn_d;
  logic                 memWrEn_q, memWrEn_d;
  logic                 memToReg_q, memToReg_d;
  logic                 aluSrc_q, aluSrc_d;
  logic                 regDst_q, regDst_d;
  logic [NB_ALU_OP-1:0] aluOp_q, aluOp_d;
  logic [NB_CNT-1:0]    stallCnt_q, stallCnt_d;

  logic                 hazard;

  // A load sitting in EX whose destination (rt, never r0) is a source of the
  // instruction in ID cannot be forwarded in time, so ID must wait one cycle.
  assign hazard = memRdEn_q & (rt_q != '0) &
                  ((rt_q == i_rs) | (i_uses_rt & (rt_q == i_rt)));

  // Stall is suppressed by reset, by a debug freeze and by a flush (the
  // dependent instruction is being squashed anyway).
  assign o_stall = hazard & i_valid & ~i_flush & ~i_rst;

  // Next-state selection: freeze holds everything, flush or hazard loads the
  // bubble (only a hazard bumps the saturating counter), otherwise capture ID.
  always_comb begin
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    dataA_d    = dataA_q;
    dataB_d    = dataB_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    regWrEn_d  = regWrEn_q;
    memRdEn_d  = memRdEn_q;
    memWrEn_d  = memWrEn_q;
    memToReg_d = memToReg_q;
    aluSrc_d   = aluSrc_q;
    regDst_d   = regDst_q;
    aluOp_d    = aluOp_q;
    stallCnt_d = stallCnt_q;
    if (i_valid) begin
      if (i_flush || hazard) begin
        rs_d       = '0;
        rt_d       = '0;
        rd_d       = '0;
        dataA_d    = '0;
        dataB_d    = '0;
        imm_d      = '0;
        pc_d       = '0;
        regWrEn_d  = 1'b0;
        memRdEn_d  = 1'b0;
        memWrEn_d  = 1'b0;
        memToReg_d = 1'b0;
        aluSrc_d   = 1'b0;
        regDst_d   = 1'b0;
        aluOp_d    = '0;
        if (!i_flush && (stallCnt_q != '1)) begin
          stallCnt_d = stallCnt_q + NB_CNT'(1);
        end
      end else begin
        rs_d       = i_rs;
        rt_d       = i_rt;
        rd_d       = i_rd;
        dataA_d    = i_data_a;
        dataB_d    = i_data_b;
        imm_d      = i_imm;
        pc_d       = i_pc;
        regWrEn_d  = i_reg_wr_en;
        memRdEn_d  = i_mem_rd_en;
        memWrEn_d  = i_mem_wr_en;
        memToReg_d = i_mem_to_reg;
        aluSrc_d   = i_alu_src;
        regDst_d   = i_reg_dst;
        aluOp_d    = i_alu_op;
      end
    end
  end

  // Pipeline register with synchronous reset to the bubble and a zero count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      dataA_q    <= '0;
      dataB_q    <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      regWrEn_q  <= 1'b0;
      memRdEn_q  <= 1'b0;
      memWrEn_q  <= 1'b0;
      memToReg_q <= 1'b0;
      aluSrc_q   <= 1'b0;
      regDst_q   <= 1'b0;
      aluOp_q    <= '0;
      stallCnt_q <= '0;
    end else begin
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      dataA_q    <= dataA_d;
      dataB_q    <= dataB_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      regWrEn_q  <= regWrEn_d;
      memRdEn_q  <= memRdEn_d;
      memWrEn_q  <= memWrEn_d;
      memToReg_q <= memToReg_d;
      aluSrc_q   <= aluSrc_d;
      regDst_q   <= regDst_d;
      aluOp_q    <= aluOp_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign o_rs         = rs_q;
  assign o_rt         = rt_q;
  assign o_rd         = rd_q;
  assign o_data_a     = dataA_q;
  assign o_data_b     = dataB_q;
  assign o_imm        = imm_q;
  assign o_pc         = pc_q;
  assign o_reg_wr_en  = regWrEn_q;
  assign o_mem_rd_en  = memRdEn_q;
  assign o_mem_wr_en  = memWrEn_q;
  assign o_mem_to_reg = memToReg_q;
  assign o_alu_src    = aluSrc_q;
  assign o_reg_dst    = regDst_q;
  assign o_alu_op     = aluOp_q;
  assign o_stall_cnt  = stallCnt_q;

endmodule

// File: tb/tb_id_ex_latch.sv
// Testbench for id_ex_latch: a directed vector table, a saturation sequence
// on a narrow-counter instance, and randomized traffic against a reference
// model of the pipeline register.

module tb_id_ex_latch;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        regWr;
    logic        memRd;
    logic        memWr;
    logic        memToReg;
    logic        aluSrc;
    logic        regDst;
    logic [3:0]  aluOp;
  } state_t;

  typedef struct packed {
    logic   rst;
    logic   valid;
    logic   flush;
    logic   usesRt;
    state_t f;
  } inVec_t;

  typedef struct {
    inVec_t in;
    int     expStall;
    int     expRs;
    int     expRt;
    int     expRd;
    int     expMemRd;
    int     expDataA;
    int     expAluOp;
    int     expRegWr;
    int     expCnt;
  } row_t;

  logic        clk;
  logic        rst, valid, flush, usesRt;
  logic [4:0]  rs, rt, rd;
  logic [31:0] dataA, dataB, imm, pc;
  logic        regWr, memRd, memWr, memToReg, aluSrc, regDst;
  logic [3:0]  aluOp;

  logic [4:0]  oRs, oRt, oRd;
  logic [31:0] oDataA, oDataB, oImm, oPc;
  logic        oRegWr, oMemRd, oMemWr, oMemToReg, oAluSrc, oRegDst;
  logic [3:0]  oAluOp;
  logic        oStall;
  logic [15:0] oCnt;

  logic [4:0]  smRs, smRt, smRd;
  logic [31:0] smDataA, smDataB, smImm, smPc;
  logic        smRegWr, smMemRd, smMemWr, smMemToReg, smAluSrc, smRegDst;
  logic [3:0]  smAluOp;
  logic        smStall;
  logic [1:0]  smCnt;

  int nCompared   = 0;
  int nMismatched = 0;

  state_t model;
  int     modelHazards;

  id_ex_latch dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_flush(flush),
    .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_uses_rt(usesRt),
    .i_data_a(dataA), .i_data_b(dataB), .i_imm(imm), .i_pc(pc),
    .i_reg_wr_en(regWr), .i_mem_rd_en(memRd), .i_mem_wr_en(memWr),
    .i_mem_to_reg(memToReg), .i_alu_src(aluSrc), .i_reg_dst(regDst),
    .i_alu_op(aluOp),
    .o_rs(oRs), .o_rt(oRt), .o_rd(oRd),
    .o_data_a(oDataA), .o_data_b(oDataB), .o_imm(oImm), .o_pc(oPc),
    .o_reg_wr_en(oRegWr), .o_mem_rd_en(oMemRd), .o_mem_wr_en(oMemWr),
    .o_mem_to_reg(oMemToReg), .o_alu_src(oAluSrc), .o_reg_dst(oRegDst),
    .o_alu_op(oAluOp), .o_stall(oStall), .o_stall_cnt(oCnt)
  );

  id_ex_latch #(.NB_CNT(2)) dutSmall (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_flush(flush),
    .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_uses_rt(usesRt),
    .i_data_a(dataA), .i_data_b(dataB), .i_imm(imm), .i_pc(pc),
    .i_reg_wr_en(regWr), .i_mem_rd_en(memRd), .i_mem_wr_en(memWr),
    .i_mem_to_reg(memToReg), .i_alu_src(aluSrc), .i_reg_dst(regDst),
    .i_alu_op(aluOp),
    .o_rs(smRs), .o_rt(smRt), .o_rd(smRd),
    .o_data_a(smDataA), .o_data_b(smDataB), .o_imm(smImm), .o_pc(smPc),
    .o_reg_wr_en(smRegWr), .o_mem_rd_en(smMemRd), .o_mem_wr_en(smMemWr),
    .o_mem_to_reg(smMemToReg), .o_alu_src(smAluSrc), .o_reg_dst(smRegDst),
    .o_alu_op(smAluOp), .o_stall(smStall), .o_stall_cnt(smCnt)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] time limit exceeded");
  end

  function automatic inVec_t mkIn(int r, int v, int fl, int s, int t, int d,
                                  int u, int m, int da, int op, int w);
    inVec_t x;
    x.rst        = r[0];
    x.valid      = v[0];
    x.flush      = fl[0];
    x.usesRt     = u[0];
    x.f.rs       = s[4:0];
    x.f.rt       = t[4:0];
    x.f.rd       = d[4:0];
    x.f.dataA    = da;
    x.f.dataB    = da ^ 32'h5A5A_0000;
    x.f.imm      = da + 32'h100;
    x.f.pc       = da + 32'h400;
    x.f.regWr    = w[0];
    x.f.memRd    = m[0];
    x.f.memWr    = 1'b0;
    x.f.memToReg = m[0];
    x.f.aluSrc   = m[0];
    x.f.regDst   = ~m[0];
    x.f.aluOp    = op[3:0];
    return x;
  endfunction

  function automatic row_t mkRow(inVec_t in, int st, int ers, int ert, int erd,
                                 int emr, int eda, int eop, int erw, int ecnt);
    row_t r;
    r.in       = in;
    r.expStall = st;
    r.expRs    = ers;
    r.expRt    = ert;
    r.expRd    = erd;
    r.expMemRd = emr;
    r.expDataA = eda;
    r.expAluOp = eop;
    r.expRegWr = erw;
    r.expCnt   = ecnt;
    return r;
  endfunction

  function automatic state_t dutState();
    return '{oRs, oRt, oRd, oDataA, oDataB, oImm, oPc,
             oRegWr, oMemRd, oMemWr, oMemToReg, oAluSrc, oRegDst, oAluOp};
  endfunction

  function automatic state_t dutStateSmall();
    return '{smRs, smRt, smRd, smDataA, smDataB, smImm, smPc,
             smRegWr, smMemRd, smMemWr, smMemToReg, smAluSrc, smRegDst, smAluOp};
  endfunction

  function automatic int satSmall(int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] act,
                             input logic [159:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input inVec_t v);
    @(negedge clk);
    rst      = v.rst;
    valid    = v.valid;
    flush    = v.flush;
    usesRt   = v.usesRt;
    rs       = v.f.rs;
    rt       = v.f.rt;
    rd       = v.f.rd;
    dataA    = v.f.dataA;
    dataB    = v.f.dataB;
    imm      = v.f.imm;
    pc       = v.f.pc;
    regWr    = v.f.regWr;
    memRd    = v.f.memRd;
    memWr    = v.f.memWr;
    memToReg = v.f.memToReg;
    aluSrc   = v.f.aluSrc;
    regDst   = v.f.regDst;
    aluOp    = v.f.aluOp;
    #1;
  endtask

  // One pipeline cycle: drive inputs, sample the stall away from the edge,
  // clock, then advance the reference model. A load whose rt (not r0) is
  // needed by the instruction in ID forces exactly one bubble.
  task automatic doCycle(input inVec_t v, output logic stallSeen,
                         output logic smStallSeen, output logic mStall);
    logic loadUse;
    applyStimulus(v);
    loadUse = model.memRd && (model.rt != 5'd0) &&
              ((model.rt == v.f.rs) || (v.usesRt && (model.rt == v.f.rt)));
    mStall      = !v.rst && v.valid && !v.flush && loadUse;
    stallSeen   = oStall;
    smStallSeen = smStall;
    @(posedge clk);
    #1;
    if (v.rst) begin
      model        = '0;
      modelHazards = 0;
    end else if (v.valid) begin
      if (v.flush) begin
        model = '0;
      end else if (loadUse) begin
        model = '0;
        modelHazards++;
      end else begin
        model = v.f;
      end
    end
  endtask

  row_t   rows[24];
  inVec_t v;
  logic   st, smSt, mSt;

  initial begin
    model        = '0;
    modelHazards = 0;
    applyStimulus(mkIn(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //                 rst v fl rs rt rd u  m  dataA       op w     st rs rt rd m  dataA      op w  cnt
    rows[0]  = mkRow(mkIn(1, 1, 0, 3, 5, 7, 1, 1, 32'hDEAD, 9, 1), 0, 0, 0, 0, 0, 0,         0, 0, 0);
    rows[1]  = mkRow(mkIn(1, 1, 0, 3, 5, 7, 1, 1, 32'hBEEF, 9, 1), 0, 0, 0, 0, 0, 0,         0, 0, 0);
    rows[2]  = mkRow(mkIn(0, 1, 0,14,12, 4, 1, 0, 32'h11,   2, 1), 0,14,12, 4, 0, 32'h11,    2, 1, 0);
    rows[3]  = mkRow(mkIn(0, 1, 0, 1,12, 0, 0, 1, 32'h22,   0, 1), 0, 1,12, 0, 1, 32'h22,    0, 1, 0);
    rows[4]  = mkRow(mkIn(0, 1, 0,12, 3, 8, 1, 0, 32'h33,   5, 1), 1, 0, 0, 0, 0, 0,         0, 0, 1);
    rows[5]  = mkRow(mkIn(0, 1, 0,12, 3, 8, 1, 0, 32'h33,   5, 1), 0,12, 3, 8, 0, 32'h33,    5, 1, 1);
    rows[6]  = mkRow(mkIn(0, 1, 0, 2, 0, 0, 0, 1, 32'h44,   0, 1), 0, 2, 0, 0, 1, 32'h44,    0, 1, 1);
    rows[7]  = mkRow(mkIn(0, 1, 0, 0, 0, 9, 1, 0, 32'h55,   1, 1), 0, 0, 0, 9, 0, 32'h55,    1, 1, 1);
    rows[8]  = mkRow(mkIn(0, 1, 0, 4,12, 0, 0, 1, 32'h66,   0, 1), 0, 4,12, 0, 1, 32'h66,    0, 1, 1);
    rows[9]  = mkRow(mkIn(0, 1, 0, 4,12,13, 0, 0, 32'h77,   3, 1), 0, 4,12,13, 0, 32'h77,    3, 1, 1);
    rows[10] = mkRow(mkIn(0, 1, 0, 1, 9, 0, 1, 1, 32'h88,   0, 1), 0, 1, 9, 0, 1, 32'h88,    0, 1, 1);
    rows[11] = mkRow(mkIn(0, 1, 0, 2,10, 0, 0, 1, 32'h99,   0, 1), 0, 2,10, 0, 1, 32'h99,    0, 1, 1);
    rows[12] = mkRow(mkIn(0, 1, 0,10,11, 0, 0, 1, 32'hAA,   0, 1), 1, 0, 0, 0, 0, 0,         0, 0, 2);
    rows[13] = mkRow(mkIn(0, 1, 0,10,11, 0, 0, 1, 32'hAA,   0, 1), 0,10,11, 0, 1, 32'hAA,    0, 1, 2);
    rows[14] = mkRow(mkIn(0, 1, 1,11, 0, 3, 1, 0, 32'hBB,   4, 1), 0, 0, 0, 0, 0, 0,         0, 0, 2);
    rows[15] = mkRow(mkIn(0, 1, 0, 1, 6, 0, 0, 1, 32'hCC,   0, 1), 0, 1, 6, 0, 1, 32'hCC,    0, 1, 2);
    rows[16] = mkRow(mkIn(0, 0, 0, 6, 2, 5, 1, 0, 32'hD1,   7, 1), 0, 1, 6, 0, 1, 32'hCC,    0, 1, 2);
    rows[17] = mkRow(mkIn(0, 0, 0, 7, 8, 5, 1, 1, 32'hD2,   6, 0), 0, 1, 6, 0, 1, 32'hCC,    0, 1, 2);
    rows[18] = mkRow(mkIn(0, 0, 0, 9, 9, 1, 1, 0, 32'hD3,   8, 1), 0, 1, 6, 0, 1, 32'hCC,    0, 1, 2);
    rows[19] = mkRow(mkIn(0, 1, 0, 6, 2, 5, 1, 0, 32'hD1,   7, 1), 1, 0, 0, 0, 0, 0,         0, 0, 3);
    rows[20] = mkRow(mkIn(0, 1, 0, 6, 2, 5, 1, 0, 32'hD1,   7, 1), 0, 6, 2, 5, 0, 32'hD1,    7, 1, 3);
    rows[21] = mkRow(mkIn(0, 1, 0, 1, 5, 0, 0, 1, 32'hE1,   0, 1), 0, 1, 5, 0, 1, 32'hE1,    0, 1, 3);
    rows[22] = mkRow(mkIn(1, 1, 0, 5, 0, 2, 1, 0, 32'hE2,   1, 1), 0, 0, 0, 0, 0, 0,         0, 0, 0);
    rows[23] = mkRow(mkIn(0, 1, 0, 5, 0, 2, 1, 0, 32'hE2,   1, 1), 0, 5, 0, 2, 0, 32'hE2,    1, 1, 0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 24; i++) begin
      doCycle(rows[i].in, st, smSt, mSt);
      checkOutput($sformatf("row%0d_stall", i), st, rows[i].expStall);
      checkOutput($sformatf("row%0d_rs", i), oRs, rows[i].expRs);
      checkOutput($sformatf("row%0d_rt", i), oRt, rows[i].expRt);
      checkOutput($sformatf("row%0d_rd", i), oRd, rows[i].expRd);
      checkOutput($sformatf("row%0d_memrd", i), oMemRd, rows[i].expMemRd);
      checkOutput($sformatf("row%0d_dataa", i), oDataA, rows[i].expDataA);
      checkOutput($sformatf("row%0d_aluop", i), oAluOp, rows[i].expAluOp);
      checkOutput($sformatf("row%0d_regwr", i), oRegWr, rows[i].expRegWr);
      checkOutput($sformatf("row%0d_cnt", i), oCnt, rows[i].expCnt);
      checkOutput($sformatf("row%0d_smcnt", i), smCnt, satSmall(rows[i].expCnt));
      if (rows[i].in.rst || rows[i].expStall != 0 || rows[i].in.flush) begin
        checkOutput($sformatf("row%0d_bubble", i), dutState(), '0);
      end
    end

    $display("[TB] counter saturation sequence");
    for (int k = 1; k <= 5; k++) begin
      doCycle(mkIn(0, 1, 0, 0, 7, 0, 0, 1, 32'h1000 + k, 0, 1), st, smSt, mSt);
      checkOutput($sformatf("sat%0d_load_stall", k), st, 1'b0);
      doCycle(mkIn(0, 1, 0, 7, 1, 3, 1, 0, 32'h2000 + k, 2, 1), st, smSt, mSt);
      checkOutput($sformatf("sat%0d_use_stall", k), st, 1'b1);
      checkOutput($sformatf("sat%0d_cnt", k), oCnt, k);
      checkOutput($sformatf("sat%0d_smcnt", k), smCnt, satSmall(k));
      doCycle(mkIn(0, 1, 0, 7, 1, 3, 1, 0, 32'h2000 + k, 2, 1), st, smSt, mSt);
      checkOutput($sformatf("sat%0d_resume_stall", k), st, 1'b0);
      checkOutput($sformatf("sat%0d_resume_rs", k), oRs, 5'd7);
    end

    $display("[TB] randomized traffic against reference model");
    for (int n = 0; n < 400; n++) begin
      v.rst        = ($urandom_range(0, 59) == 0);
      v.valid      = ($urandom_range(0, 99) < 85);
      v.flush      = ($urandom_range(0, 9) == 0);
      v.usesRt     = $urandom_range(0, 1) == 1;
      v.f.rs       = 5'($urandom_range(0, 3));
      v.f.rt       = 5'($urandom_range(0, 3));
      v.f.rd       = 5'($urandom_range(0, 31));
      v.f.dataA    = $urandom;
      v.f.dataB    = $urandom;
      v.f.imm      = $urandom;
      v.f.pc       = $urandom;
      v.f.regWr    = $urandom_range(0, 1) == 1;
      v.f.memRd    = ($urandom_range(0, 9) < 4);
      v.f.memWr    = $urandom_range(0, 1) == 1;
      v.f.memToReg = $urandom_range(0, 1) == 1;
      v.f.aluSrc   = $urandom_range(0, 1) == 1;
      v.f.regDst   = $urandom_range(0, 1) == 1;
      v.f.aluOp    = 4'($urandom_range(0, 15));
      doCycle(v, st, smSt, mSt);
      checkOutput($sformatf("rnd%0d_stall", n), st, mSt);
      checkOutput($sformatf("rnd%0d_smstall", n), smSt, mSt);
      checkOutput($sformatf("rnd%0d_state", n), dutState(), model);
      checkOutput($sformatf("rnd%0d_smstate", n), dutStateSmall(), model);
      checkOutput($sformatf("rnd%0d_cnt", n), oCnt, modelHazards);
      checkOutput($sformatf("rnd%0d_smcnt", n), smCnt, satSmall(modelHazards));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
